icache_param: RTL and testbench

//  Parametrised direct-mapped instruction cache; successor to the fixed 1-word-block icache.

---
 rtl/icache_param.sv | 130 +++++++++++++
 tb/tb_icache_param.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_param.sv
// Direct-mapped instruction cache with configurable set count and block size.
// Misses are served by a sequential refill that reads one word per memory handshake.
module icache_param #(
    parameter int unsigned NSETS    = 16,
    parameter int unsigned BLKWORDS = 2,
    parameter int unsigned WORD_W   = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              halt,
    input  logic              imemREN,
    input  logic [WORD_W-1:0] imemaddr,
    output logic              ihit,
    output logic [WORD_W-1:0] imemload,
    output logic              iREN,
    output logic [WORD_W-1:0] iaddr,
    input  logic [WORD_W-1:0] iload,
    input  logic              iwait
);

    localparam int unsigned WO_W   = $clog2(BLKWORDS);
    localparam int unsigned CNT_W  = (WO_W == 0) ? 1 : WO_W;
    localparam int unsigned IDX_W  = $clog2(NSETS);
    localparam int unsigned PTR_W  = IDX_W + WO_W;
    localparam int unsigned TAG_W  = WORD_W - 2 - PTR_W;
    localparam int unsigned NWORDS = NSETS * BLKWORDS;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BLKWORDS - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FILL = 1'b1;

    logic [0:0]        state, state_next;
    logic [CNT_W-1:0]  count, count_next;
    logic [TAG_W-1:0]  fill_tag;
    logic [IDX_W-1:0]  fill_idx;
    logic [NSETS-1:0]  valid;
    logic [TAG_W-1:0]  tags [NSETS];
    logic [WORD_W-1:0] data [NWORDS];

    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic              lookup_hit, start_fill, data_we, fill_done;
    logic              unused_bits;

    // {index, word offset} is contiguous in the address, so it directly addresses the flat data array
    assign req_idx     = imemaddr[2+WO_W +: IDX_W];
    assign req_tag     = imemaddr[WORD_W-1 -: TAG_W];
    assign rd_ptr      = imemaddr[2 +: PTR_W];
    assign wr_ptr      = (PTR_W'(fill_idx) << WO_W) | PTR_W'(count);
    assign lookup_hit  = imemREN & ~halt & valid[req_idx] & (tags[req_idx] == req_tag);
    assign unused_bits = ^imemaddr[1:0];

    // State, fill bookkeeping and valid bits
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            count    <= '0;
            valid    <= '0;
            fill_tag <= '0;
            fill_idx <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (start_fill) begin
                fill_tag         <= req_tag;
                fill_idx         <= req_idx;
                valid[req_idx]   <= 1'b0;
            end
            if (fill_done) begin
                valid[fill_idx] <= 1'b1;
            end
        end
    end

    // Tag and data storage carry no reset; the valid bits guard them
    always_ff @(posedge CLK) begin
        if (data_we) begin
            data[wr_ptr] <= iload;
        end
        if (fill_done) begin
            tags[fill_idx] <= fill_tag;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        start_fill = 1'b0;
        data_we    = 1'b0;
        fill_done  = 1'b0;
        ihit       = 1'b0;
        imemload   = '0;
        iREN       = 1'b0;
        iaddr      = '0;
        case (state)
            IDLE: begin
                ihit = lookup_hit;
                if (lookup_hit) begin
                    imemload = data[rd_ptr];
                end
                if (imemREN && !halt && !lookup_hit) begin
                    state_next = FILL;
                    count_next = '0;
                    start_fill = 1'b1;
                end
            end
            FILL: begin
                iREN  = 1'b1;
                iaddr = (WORD_W'({fill_tag, fill_idx}) << (WO_W + 2)) | (WORD_W'(count) << 2);
                // halt abandons the block; its valid bit was already cleared on entry
                if (halt) begin
                    state_next = IDLE;
                    count_next = '0;
                end else if (!iwait) begin
                    data_we = 1'b1;
                    if (count == LAST) begin
                        fill_done  = 1'b1;
                        state_next = IDLE;
                        count_next = '0;
                    end else begin
                        count_next = count + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_icache_param.sv
// Bench for icache_param: three configurations sharing one memory model, checked
// against a set/tag reference model computed from address arithmetic.
module tb_icache_param;

    logic        CLK = 1'b0;
    logic        RST;
    logic        halt;
    logic [31:0] imemaddr;
    logic [2:0]  imem_ren;
    logic [2:0]  ihit;
    logic [2:0]  iren;
    logic [2:0]  iwait;
    logic [31:0] imemload [3];
    logic [31:0] iaddr    [3];
    logic [31:0] iload    [3];

    int passed = 0;
    int total  = 0;

    int unsigned lat_min = 0;
    int unsigned lat_max = 0;
    int unsigned wcnt [3];
    int unsigned lat  [3];
    bit          served [3];
    logic [31:0] hs_q [$];

    bit          m_valid [3][64];
    logic [31:0] m_tag   [3][64];

    always #5 CLK = ~CLK;

    icache_param #(.NSETS(16), .BLKWORDS(2), .WORD_W(32)) dut0 (
        .CLK(CLK), .RST(RST), .halt(halt), .imemREN(imem_ren[0]), .imemaddr(imemaddr),
        .ihit(ihit[0]), .imemload(imemload[0]), .iREN(iren[0]), .iaddr(iaddr[0]),
        .iload(iload[0]), .iwait(iwait[0]));

    icache_param #(.NSETS(4), .BLKWORDS(1), .WORD_W(32)) dut1 (
        .CLK(CLK), .RST(RST), .halt(halt), .imemREN(imem_ren[1]), .imemaddr(imemaddr),
        .ihit(ihit[1]), .imemload(imemload[1]), .iREN(iren[1]), .iaddr(iaddr[1]),
        .iload(iload[1]), .iwait(iwait[1]));

    icache_param #(.NSETS(64), .BLKWORDS(8), .WORD_W(32)) dut2 (
        .CLK(CLK), .RST(RST), .halt(halt), .imemREN(imem_ren[2]), .imemaddr(imemaddr),
        .ihit(ihit[2]), .imemload(imemload[2]), .iREN(iren[2]), .iaddr(iaddr[2]),
        .iload(iload[2]), .iwait(iwait[2]));

    function automatic int unsigned ns_of(input int g);
        return (g == 0) ? 16 : (g == 1) ? 4 : 64;
    endfunction

    function automatic int unsigned blk_of(input int g);
        return (g == 0) ? 2 : (g == 1) ? 1 : 8;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ((a & ~32'h3) * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    function automatic int set_of(input int g, input logic [31:0] a);
        return int'(((a >> 2) / blk_of(g)) % ns_of(g));
    endfunction

    function automatic logic [31:0] tag_of(input int g, input logic [31:0] a);
        return ((a >> 2) / blk_of(g)) / ns_of(g);
    endfunction

    // Memory with a per-word latency drawn from [lat_min, lat_max]
    always @(negedge CLK) begin
        for (int g = 0; g < 3; g++) begin
            if (!iren[g] || served[g]) begin
                wcnt[g] = 0;
                lat[g]  = $urandom_range(lat_max, lat_min);
            end
            served[g] = 1'b0;
            if (iren[g] && wcnt[g] >= lat[g]) begin
                iwait[g]  = 1'b0;
                iload[g]  = mem_word(iaddr[g]);
                served[g] = 1'b1;
            end else begin
                iwait[g] = 1'b1;
                iload[g] = $urandom;
                if (iren[g]) wcnt[g] = wcnt[g] + 1;
            end
        end
    end

    // Log of completed memory handshakes (address seen at the consuming edge)
    always @(posedge CLK) begin
        for (int g = 0; g < 3; g++) begin
            if (!RST && iren[g] && !iwait[g]) hs_q.push_back(iaddr[g]);
        end
    end

    task automatic model_clear();
        for (int g = 0; g < 3; g++)
            for (int s = 0; s < 64; s++) m_valid[g][s] = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        model_clear();
    endtask

    // One fetch, followed to completion; hit/miss predicted by the reference model
    task automatic fetch(input int g, input logic [31:0] a, output int cyc, output bit was_hit);
        int          s;
        int          base;
        bit          hs_ok;
        logic [31:0] t;
        logic [31:0] blk_base;
        s        = set_of(g, a);
        t        = tag_of(g, a);
        was_hit  = m_valid[g][s] && (m_tag[g][s] == t);
        blk_base = a - (a % (4 * blk_of(g)));
        cyc      = 0;
        @(posedge CLK); #1;
        base        = hs_q.size();
        imemaddr    = a;
        imem_ren[g] = 1'b1;
        @(negedge CLK);
        total++;
        if (ihit[g] !== was_hit) $display("FAIL lookup g%0d addr=%h: ihit=%b expected %b", g, a, ihit[g], was_hit);
        else passed++;
        if (was_hit) begin
            total++;
            if (imemload[g] !== mem_word(a) || iren[g] !== 1'b0)
                $display("FAIL hit_data g%0d addr=%h: data=%h iREN=%b expected %h/0", g, a, imemload[g], iren[g], mem_word(a));
            else passed++;
        end else begin
            m_valid[g][s] = 1'b0;
            while (ihit[g] !== 1'b1 && cyc < 200) begin
                @(negedge CLK);
                cyc++;
            end
            total++;
            if (ihit[g] !== 1'b1) $display("FAIL refill_timeout g%0d addr=%h: ihit=%b after %0d cycles expected 1", g, a, ihit[g], cyc);
            else passed++;
            total++;
            if (imemload[g] !== mem_word(a)) $display("FAIL fill_data g%0d addr=%h: data=%h expected %h", g, a, imemload[g], mem_word(a));
            else passed++;
            hs_ok = (hs_q.size() - base) == int'(blk_of(g));
            for (int k = 0; k < int'(blk_of(g)) && hs_ok; k++)
                if (hs_q[base + k] !== blk_base + 32'(4 * k)) hs_ok = 1'b0;
            total++;
            if (!hs_ok) $display("FAIL fill_addrs g%0d addr=%h: %0d reads, first=%h expected %0d reads from %h",
                                 g, a, hs_q.size() - base, (hs_q.size() > base) ? hs_q[base] : 32'h0, blk_of(g), blk_base);
            else passed++;
            m_valid[g][s] = 1'b1;
            m_tag[g][s]   = t;
        end
        @(posedge CLK); #1;
        imem_ren[g] = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge CLK);
        for (int g = 0; g < 3; g++) begin
            total++;
            if (ihit[g] !== 1'b0 || iren[g] !== 1'b0 || iaddr[g] !== 32'h0 || imemload[g] !== 32'h0)
                $display("FAIL reset g%0d: ihit=%b iREN=%b iaddr=%h imemload=%h expected all 0", g, ihit[g], iren[g], iaddr[g], imemload[g]);
            else passed++;
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        total++;
        if (ihit !== 3'b000 || iren !== 3'b000) $display("FAIL post_reset_idle: ihit=%b iREN=%b expected 000/000", ihit, iren);
        else passed++;
    endtask

    task automatic test_cold_fill();
        int cyc;
        bit h;
        lat_min = 1;
        lat_max = 1;
        fetch(0, 32'h40, cyc, h);
        total++;
        if (h || cyc != 5) $display("FAIL cold_latency: hit=%b cycles=%0d expected miss with 5", h, cyc);
        else passed++;
    endtask

    task automatic test_same_block();
        int cyc;
        bit h;
        fetch(0, 32'h44, cyc, h);
        total++;
        if (!h) $display("FAIL same_block: hit=%b expected 1", h);
        else passed++;
    endtask

    task automatic test_conflict();
        int cyc;
        bit h;
        lat_min = 0;
        lat_max = 2;
        fetch(0, 32'hC0, cyc, h);
        total++;
        if (h) $display("FAIL conflict_c0: hit=%b expected 0", h);
        else passed++;
        fetch(0, 32'h40, cyc, h);
        total++;
        if (h) $display("FAIL conflict_40_refetch: hit=%b expected 0", h);
        else passed++;
    endtask

    task automatic test_halt();
        int cyc;
        bit h;
        lat_min = 0;
        lat_max = 0;
        // halt on a hit suppresses ihit and zeroes imemload
        @(posedge CLK); #1;
        imemaddr    = 32'h40;
        imem_ren[0] = 1'b1;
        halt        = 1'b1;
        @(negedge CLK);
        total++;
        if (ihit[0] !== 1'b0 || imemload[0] !== 32'h0) $display("FAIL halt_on_hit: ihit=%b data=%h expected 0/0", ihit[0], imemload[0]);
        else passed++;
        @(posedge CLK); #1;
        halt     = 1'b0;
        imemaddr = 32'h100;
        @(negedge CLK);
        total++;
        if (ihit[0] !== 1'b0) $display("FAIL halt_miss_start: ihit=%b expected 0", ihit[0]);
        else passed++;
        m_valid[0][set_of(0, 32'h100)] = 1'b0;
        @(posedge CLK);
        @(posedge CLK); #1;
        halt = 1'b1;
        @(negedge CLK);
        total++;
        if (ihit[0] !== 1'b0) $display("FAIL halt_in_fill: ihit=%b expected 0", ihit[0]);
        else passed++;
        @(negedge CLK);
        total++;
        if (iren[0] !== 1'b0 || ihit[0] !== 1'b0) $display("FAIL halt_drop: iREN=%b ihit=%b expected 0/0", iren[0], ihit[0]);
        else passed++;
        @(posedge CLK); #1;
        halt        = 1'b0;
        imem_ren[0] = 1'b0;
        fetch(0, 32'h100, cyc, h);
        total++;
        if (h) $display("FAIL halt_partial_visible: hit=%b expected 0", h);
        else passed++;
    endtask

    task automatic test_nonabort();
        int cyc;
        bit h;
        int base;
        int n;
        lat_min = 1;
        lat_max = 1;
        @(posedge CLK); #1;
        base        = hs_q.size();
        imemaddr    = 32'h200;
        imem_ren[0] = 1'b1;
        @(negedge CLK);
        m_valid[0][set_of(0, 32'h200)] = 1'b0;
        @(posedge CLK); #1;
        imemaddr    = 32'h40;
        imem_ren[0] = 1'b0;
        n = 0;
        while (hs_q.size() < base + 2 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        total++;
        if (hs_q.size() != base + 2 || hs_q[base] !== 32'h200 || hs_q[base + 1] !== 32'h204)
            $display("FAIL nonabort_reads: %0d reads first=%h expected 2 reads 200,204", hs_q.size() - base,
                     (hs_q.size() > base) ? hs_q[base] : 32'h0);
        else passed++;
        m_valid[0][set_of(0, 32'h200)] = 1'b1;
        m_tag[0][set_of(0, 32'h200)]   = tag_of(0, 32'h200);
        fetch(0, 32'h204, cyc, h);
        total++;
        if (!h) $display("FAIL nonabort_installed: hit=%b expected 1", h);
        else passed++;
    endtask

    task automatic test_rst_mid_fill();
        int cyc;
        bit h;
        lat_min = 2;
        lat_max = 2;
        @(posedge CLK); #1;
        imemaddr    = 32'h300;
        imem_ren[0] = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        #1;
        total++;
        if (iren[0] !== 1'b0 || ihit[0] !== 1'b0) $display("FAIL rst_mid_fill: iREN=%b ihit=%b expected 0/0", iren[0], ihit[0]);
        else passed++;
        @(posedge CLK); #1;
        RST         = 1'b0;
        imem_ren[0] = 1'b0;
        model_clear();
        fetch(0, 32'h40, cyc, h);
        total++;
        if (h) $display("FAIL rst_invalidates: hit=%b expected 0", h);
        else passed++;
    endtask

    task automatic test_sweep(input int g, input int n);
        int          cyc;
        bit          h;
        logic [31:0] a;
        logic [31:0] prev;
        int unsigned words;
        words   = (g == 1) ? 64 : 1024;
        lat_min = 0;
        lat_max = 3;
        pulse_reset();
        prev = 32'h0;
        for (int k = 0; k < n; k++) begin
            if (k > 0 && $urandom_range(1, 0) == 1) a = prev + 32'(4 * $urandom_range(1, 0));
            else a = 32'(4 * $urandom_range(words - 1, 0));
            fetch(g, a, cyc, h);
            prev = a;
        end
    endtask

    initial begin
        RST      = 1'b1;
        halt     = 1'b0;
        imem_ren = 3'b000;
        imemaddr = 32'h0;
        model_clear();
        test_reset();
        test_cold_fill();
        test_same_block();
        test_conflict();
        test_halt();
        test_nonabort();
        test_rst_mid_fill();
        test_sweep(1, 60);
        test_sweep(2, 60);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
